// File: rtl/uart_pkg.sv
// Shared types and line levels for the 8N1 UART transceiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_START   = 3'd1,
    TX_DATA    = 3'd2,
    TX_STOP    = 3'd3,
    TX_CLEANUP = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_CLEANUP = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: wraps every CLKS_PER_BIT enabled cycles and flags
// the bit midpoint and the last cycle of the bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic mid_tick,
  output logic end_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MIDPOINT = CW'((CLKS_PER_BIT - 1) / 2);

  logic [CW-1:0] count;

  assign mid_tick = enable && (count == MIDPOINT);
  assign end_tick = enable && (count == TERMINAL);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= end_tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent TX and RX state machines sharing one
// clock and baud divisor. FSM states are visible on tx_state/rx_state.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output tx_state_t  tx_state,
  output rx_state_t  rx_state
);

  // Handshake: i_Tx_DV is a single-cycle request honoured only in TX_IDLE;
  // o_Tx_Done and o_Rx_DV are one-cycle pulses with no back-pressure.

  tx_state_t  tx_state_q, tx_state_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_clear, tx_enable, tx_end, tx_mid_unused;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk      (i_Clock),
    .reset    (i_Reset),
    .clear    (tx_clear),
    .enable   (tx_enable),
    .mid_tick (tx_mid_unused),
    .end_tick (tx_end)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= '0;
      tx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_idx_d    = tx_idx_q;
    tx_data_d   = tx_data_q;
    tx_clear    = 1'b0;
    tx_enable   = 1'b0;
    o_Tx_Serial = IDLE_LEVEL;
    o_Tx_Active = 1'b0;
    o_Tx_Done   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_clear = 1'b1;
        if (i_Tx_DV) begin
          tx_data_d  = i_Tx_Byte;
          tx_idx_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_enable   = 1'b1;
        o_Tx_Serial = START_LEVEL;
        o_Tx_Active = 1'b1;
        if (tx_end) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_enable   = 1'b1;
        o_Tx_Serial = tx_data_q[tx_idx_q];
        o_Tx_Active = 1'b1;
        if (tx_end) begin
          tx_idx_d = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'(DATA_BITS - 1)) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_enable   = 1'b1;
        o_Tx_Serial = STOP_LEVEL;
        o_Tx_Active = 1'b1;
        if (tx_end) tx_state_d = TX_CLEANUP;
      end
      TX_CLEANUP: begin
        tx_clear   = 1'b1;
        o_Tx_Done  = 1'b1;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign tx_state = tx_state_q;

  rx_state_t  rx_state_q, rx_state_d;
  logic [1:0] rx_sync;
  logic       rx_line;
  logic [2:0] rx_idx_q, rx_idx_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dv_q, rx_dv_d;
  logic       rx_clear, rx_enable, rx_mid, rx_end;

  assign rx_line = rx_sync[1];

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk      (i_Clock),
    .reset    (i_Reset),
    .clear    (rx_clear),
    .enable   (rx_enable),
    .mid_tick (rx_mid),
    .end_tick (rx_end)
  );

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_sync    <= {2{IDLE_LEVEL}};
      rx_state_q <= RX_IDLE;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[0], i_Rx_Serial};
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    rx_clear   = 1'b0;
    rx_enable  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_clear = 1'b1;
        rx_idx_d = '0;
        if (rx_line == START_LEVEL) rx_state_d = RX_START;
      end
      RX_START: begin
        rx_enable = 1'b1;
        if (rx_mid) begin
          // Restart the timer here so later samples land mid-bit.
          rx_clear   = 1'b1;
          rx_state_d = (rx_line == START_LEVEL) ? RX_DATA : RX_IDLE;
        end
      end
      RX_DATA: begin
        rx_enable = 1'b1;
        if (rx_end) begin
          rx_shift_d[rx_idx_q] = rx_line;
          rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'(DATA_BITS - 1)) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_enable = 1'b1;
        if (rx_end) begin
          if (rx_line == STOP_LEVEL) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end
          rx_state_d = RX_CLEANUP;
        end
      end
      RX_CLEANUP: begin
        rx_clear   = 1'b1;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign o_Rx_DV   = rx_dv_q;
  assign o_Rx_Byte = rx_byte_q;
  assign rx_state  = rx_state_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: TX framing, RX tolerance, glitch and
// framing-error rejection, loopback and reset mid-frame.
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int CPB = 87;

  logic       clk;
  logic       reset;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_serial;
  logic       tx_done;
  logic       rx_drv;
  logic       loop_en;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;
  tx_state_t  tx_state;
  rx_state_t  rx_state;

  int checks = 0;
  int failures = 0;
  int rx_dv_count = 0;
  logic [7:0] exp_q[$];

  assign rx_serial = loop_en ? tx_serial : rx_drv;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clk),
    .i_Reset     (reset),
    .i_Tx_DV     (tx_dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Active (tx_active),
    .o_Tx_Serial (tx_serial),
    .o_Tx_Done   (tx_done),
    .i_Rx_Serial (rx_serial),
    .o_Rx_DV     (rx_dv),
    .o_Rx_Byte   (rx_byte),
    .tx_state    (tx_state),
    .rx_state    (rx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every received byte must match the head of exp_q
  always @(negedge clk) begin
    if (rx_dv === 1'b1) begin
      rx_dv_count++;
      if (exp_q.size() == 0) check("rx_unexpected_dv", {24'h0, rx_byte}, 32'hFFFF_FFFF);
      else check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_q.pop_front()});
    end
  end

  // Starts at a negedge, ends at the negedge of frame cycle 871 (cycle 0 is
  // the negedge right after the edge that samples i_Tx_DV).
  task automatic tx_frame_check(input logic [7:0] b, input string tag);
    logic [9:0] frame;
    int active_cnt, done_cnt, done_at;
    frame = {1'b1, b, 1'b0};
    active_cnt = 0;
    done_cnt = 0;
    done_at = -1;
    tx_dv = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv = 1'b0;
    for (int cyc = 0; cyc <= 10 * CPB + 1; cyc++) begin
      if (cyc < 10 * CPB && (cyc % CPB == 0 || cyc % CPB == CPB - 1))
        check($sformatf("%s_bit%0d_c%0d", tag, cyc / CPB, cyc % CPB), {31'h0, tx_serial},
              {31'h0, frame[cyc / CPB]});
      if (cyc == 10 * CPB + 1) check($sformatf("%s_idle_line", tag), {31'h0, tx_serial}, 32'h1);
      if (tx_active) active_cnt++;
      if (tx_done) begin
        done_cnt++;
        done_at = cyc + 1;  // counted from the edge before i_Tx_DV rises
      end
      case (cyc)
        5:            tx_byte = ~b;
        300:          tx_dv = 1'b1;
        301:          tx_dv = 1'b0;
        10 * CPB:     tx_dv = 1'b1;
        10 * CPB + 1: tx_dv = 1'b0;
        default: ;
      endcase
      if (cyc < 10 * CPB + 1) @(negedge clk);
    end
    check($sformatf("%s_active_cycles", tag), active_cnt, 10 * CPB);
    check($sformatf("%s_done_pulses", tag), done_cnt, 1);
    check($sformatf("%s_done_time", tag), done_at, 10 * CPB + 1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input int bit_clks, input int start_extra,
                          input logic stop_lvl);
    rx_drv = 1'b0;
    repeat (bit_clks + start_extra) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx_drv = stop_lvl;
    repeat (bit_clks) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * bit_clks) @(negedge clk);
  endtask

  initial begin
    int done_cnt;
    reset = 1'b1;
    tx_dv = 1'b0;
    tx_byte = 8'h00;
    rx_drv = 1'b1;
    loop_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_serial", {31'h0, tx_serial}, 32'h1);
    check("rst_tx_active", {31'h0, tx_active}, 32'h0);
    check("rst_tx_done", {31'h0, tx_done}, 32'h0);
    check("rst_rx_dv", {31'h0, rx_dv}, 32'h0);
    check("rst_rx_byte", {24'h0, rx_byte}, 32'h0);
    check("rst_tx_state", 32'(tx_state), 32'(TX_IDLE));
    check("rst_rx_state", 32'(rx_state), 32'(RX_IDLE));

    tx_frame_check(8'hAB, "tx_ab");
    repeat (5) @(negedge clk);

    // 86-clock bits with a 10-clock stretched start bit
    exp_q.push_back(8'h3F);
    rx_frame(8'h3F, 86, 10, 1'b1);
    check("rx3f_dv_count", rx_dv_count, 1);
    check("rx3f_byte_hold", {24'h0, rx_byte}, 32'h3F);

    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_rx_state", 32'(rx_state), 32'(RX_IDLE));
    check("glitch_dv_count", rx_dv_count, 1);
    check("glitch_byte_hold", {24'h0, rx_byte}, 32'h3F);

    rx_frame(8'h55, 86, 0, 1'b0);
    check("frame_err_dv_count", rx_dv_count, 1);
    check("frame_err_byte_hold", {24'h0, rx_byte}, 32'h3F);
    check("frame_err_rx_state", 32'(rx_state), 32'(RX_IDLE));

    loop_en = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hA5);
    tx_frame_check(8'h00, "loop_00");
    tx_frame_check(8'hFF, "loop_ff");
    tx_frame_check(8'hA5, "loop_a5");
    repeat (150) @(negedge clk);
    check("loop_dv_count", rx_dv_count, 4);
    check("loop_queue_empty", exp_q.size(), 0);
    check("loop_last_byte", {24'h0, rx_byte}, 32'hA5);
    loop_en = 1'b0;

    // 8'hE6 puts a 0 on the line during data bit 4
    @(negedge clk);
    tx_dv = 1'b1;
    tx_byte = 8'hE6;
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (5 * CPB + 40) @(negedge clk);
    check("midrst_pre_state", 32'(tx_state), 32'(TX_DATA));
    check("midrst_pre_line", {31'h0, tx_serial}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx_serial", {31'h0, tx_serial}, 32'h1);
    check("midrst_tx_active", {31'h0, tx_active}, 32'h0);
    check("midrst_tx_done", {31'h0, tx_done}, 32'h0);
    check("midrst_tx_state", 32'(tx_state), 32'(TX_IDLE));
    check("midrst_rx_byte", {24'h0, rx_byte}, 32'h0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6 * CPB; i++) begin
      @(negedge clk);
      if (tx_done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_line_idle", {31'h0, tx_serial}, 32'h1);

    tx_frame_check(8'h3C, "post_rst");
    repeat (10) @(negedge clk);
    check("final_dv_count", rx_dv_count, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART block: one 8-bit character per frame, no parity, one stop bit, LSB first.
- Independent transmit and receive paths share one clock and one fixed baud divisor.
- Sits between the system-side byte interface (data-valid/byte strobes) and the serial pins.
- Default divisor targets 115200 baud from a 10 MHz clock.

Parameters:
- CLKS_PER_BIT, 87: clock cycles per serial bit (clock_freq / baud). Legal range is 4 or more.

Ports:
- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Reset  in  1  synchronous reset, active-high.
- i_Tx_DV  in  1  transmit request; single-cycle strobe qualifying i_Tx_Byte.
- i_Tx_Byte  in  8  byte to transmit.
- o_Tx_Active  out  1  high while a transmit frame is in progress.
- o_Tx_Serial  out  1  serial TX line; idles high.
- o_Tx_Done  out  1  one-cycle pulse when a frame completes.
- i_Rx_Serial  in  1  serial RX line (asynchronous).
- o_Rx_DV  out  1  one-cycle pulse when a valid byte has been received.
- o_Rx_Byte  out  8  last valid received byte.

Behaviour:
- Reset (synchronous, active-high):
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Rx_DV=0, o_Rx_Byte=8'h00.
  - Both FSMs go to IDLE and all counters clear.
  - Reset mid-frame aborts the frame; the TX line is high from the next cycle.
- TX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: o_Tx_Serial=1. When i_Tx_DV=1 is sampled at an edge, latch i_Tx_Byte, go to START, and set o_Tx_Active=1.
  - START: line 0 for exactly CLKS_PER_BIT cycles.
  - DATA: bits 0..7, each held exactly CLKS_PER_BIT cycles; a 3-bit index wraps 7 to STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles.
  - CLEANUP: one cycle with o_Tx_Done=1 and o_Tx_Active=0; then return to IDLE.
  - The frame occupies 10*CLKS_PER_BIT cycles; o_Tx_Done pulses in the following cycle.
  - i_Tx_DV is ignored outside IDLE, including during CLEANUP. The latched byte is unaffected by i_Tx_Byte changes mid-frame.
- RX input conditioning: i_Rx_Serial passes through a 2-flop synchronizer, initialised/reset to 1. This adds 2 cycles of latency.
- RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: wait for the synchronized line to be 0.
  - START: count to (CLKS_PER_BIT-1)/2, the bit midpoint.
    - If the line is still 0, clear the counter and go to DATA.
    - Otherwise treat it as a glitch and return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles sample the line into shift bit[index], LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the line.
    - If 1: load o_Rx_Byte with the shifted byte and pulse o_Rx_DV for one cycle.
    - If 0 (framing error): drop the byte; no DV, and o_Rx_Byte is unchanged.
  - CLEANUP: one cycle, then IDLE. This allows back-to-back frames.
- Mid-bit sampling tolerates at least ±10 clocks of start-bit stretch and a 1-clock/bit baud mismatch at the default divisor.
- o_Rx_Byte holds its value between valid frames.
- TX and RX operate fully concurrently. Loopback (o_Tx_Serial to i_Rx_Serial) must work.
- Counter widths are $clog2(CLKS_PER_BIT)+1 bits, unsigned, compared with the equality terminal count CLKS_PER_BIT-1.

Decomposition:
- Package uart_pkg holds:
  - TX and RX state enums.
  - DATA_BITS=8.
  - IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- One natural sub-module: uart_bit_timer.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clear and enable. Outputs: mid_tick and end_tick.
  - Instantiated once in the TX path and once in the RX path.
- The two FSMs stay in the top module.

Test Plan:
- TX 8'hAB with CLKS_PER_BIT=87:
  - Pulse i_Tx_DV for one cycle.
  - o_Tx_Serial emits 0,1,1,0,1,0,1,0,1,1, each bit 87 cycles.
  - o_Tx_Active is high for 870 cycles; o_Tx_Done pulses once, 871 cycles after the DV edge.
- RX 8'h3F driven at a bit period of 86 clocks with the start bit stretched by +10 clocks:
  - o_Rx_DV pulses once; o_Rx_Byte=8'h3F.
- Glitch rejection: drive i_Rx_Serial low for 20 cycles, then high.
  - No o_Rx_DV; the RX FSM returns to IDLE; o_Rx_Byte is unchanged.
- Framing error: send 8'h55 with the stop bit held at 0.
  - No o_Rx_DV; o_Rx_Byte keeps its previous value (8'h3F).
- Loopback, back-to-back: tie TX to RX and send 8'h00, 8'hFF, 8'hA5, issuing each DV one cycle after the previous o_Tx_Done.
  - Three o_Rx_DV pulses, with bytes matching in order.
- Reset mid-frame: assert i_Reset during TX bit 4.
  - Next cycle: o_Tx_Serial=1, o_Tx_Active=0, and no o_Tx_Done.
  - A new i_Tx_DV after reset transmits correctly.
